// File: rtl/sa_pkg.sv
// Shared systolic-array constants and the psum column packing helper, so the
// MAC body and the output deskew agree on where each column sits in a row.
package sa_pkg;

    localparam int DEF_PE_SIZE    = 2;
    localparam int DEF_PSUM_WIDTH = 32;
    localparam int DEF_FIFO_DEPTH = 4;

    // Column 0 occupies the most significant slice of a packed row.
    function automatic int col_lo(input int pe_size, input int width, input int col);
        return width * (pe_size - col - 1);
    endfunction

    function automatic int col_hi(input int pe_size, input int width, input int col);
        return width * (pe_size - col) - 1;
    endfunction

endpackage

// File: rtl/psum_row_fifo.sv
// Synchronous FIFO for aligned psum rows; head entry is shown combinationally.
module psum_row_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [LW-1:0] LVL_ONE = LW'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic             do_push, do_pop;

    assign empty   = (level_q == '0);
    assign full    = (level_q == LW'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);
    assign dout    = mem_q[rd_ptr_q];
    assign level   = level_q;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + LVL_ONE;
                2'b01:   level_q <= level_q - LVL_ONE;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/sa_psum_deskew.sv
// Re-aligns the staggered psum columns leaving the systolic array into full
// rows, buffers them, and flags lost or misaligned rows with sticky bits.
module sa_psum_deskew
    import sa_pkg::*;
#(
    parameter int PE_SIZE    = DEF_PE_SIZE,
    parameter int PSUM_WIDTH = DEF_PSUM_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [PSUM_WIDTH*PE_SIZE-1:0]     psum_row_i,
    input  logic [PE_SIZE-1:0]                psum_en_row_i,
    input  logic                              clear_i,
    output logic [PSUM_WIDTH*PE_SIZE-1:0]     out_row_o,
    output logic                              out_valid_o,
    input  logic                              out_ready_i,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   level_o,
    output logic                              overflow_o,
    output logic                              skew_err_o
);

    logic [PSUM_WIDTH*PE_SIZE-1:0] aligned_row;
    logic [PE_SIZE-1:0]            aligned_en;

    // Column j arrives j cycles late, so it is held PE_SIZE-1-j cycles to line up
    // with the last column, which is taken live.
    for (genvar j = 0; j < PE_SIZE; j++) begin : g_col
        localparam int LO     = col_lo(PE_SIZE, PSUM_WIDTH, j);
        localparam int EB     = PE_SIZE - 1 - j;
        localparam int STAGES = PE_SIZE - 1 - j;

        if (STAGES == 0) begin : g_live
            assign aligned_row[LO +: PSUM_WIDTH] = psum_row_i[LO +: PSUM_WIDTH];
            assign aligned_en[EB]                = psum_en_row_i[EB];
        end else begin : g_dly
            logic [PSUM_WIDTH-1:0] data_q [STAGES];
            logic [STAGES-1:0]     en_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int s = 0; s < STAGES; s++) begin
                        data_q[s] <= '0;
                    end
                    en_q <= '0;
                end else begin
                    data_q[0] <= psum_row_i[LO +: PSUM_WIDTH];
                    en_q[0]   <= psum_en_row_i[EB];
                    for (int s = 1; s < STAGES; s++) begin
                        data_q[s] <= data_q[s-1];
                        en_q[s]   <= en_q[s-1];
                    end
                end
            end

            assign aligned_row[LO +: PSUM_WIDTH] = data_q[STAGES-1];
            assign aligned_en[EB]                = en_q[STAGES-1];
        end
    end

    logic row_complete, row_idle, skew_event, ovf_event;
    logic fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic overflow_q, overflow_d, skew_err_q, skew_err_d;

    assign row_complete = &aligned_en;
    assign row_idle     = ~|aligned_en;
    assign skew_event   = ~row_complete & ~row_idle;

    assign out_valid_o = ~fifo_empty;
    assign fifo_pop    = out_valid_o & out_ready_i;
    assign fifo_push   = row_complete & (~fifo_full | fifo_pop);
    assign ovf_event   = row_complete & fifo_full & ~fifo_pop;

    psum_row_fifo #(
        .WIDTH (PSUM_WIDTH*PE_SIZE),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (aligned_row),
        .dout  (out_row_o),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level_o)
    );

    // A new error event beats a simultaneous clear.
    always_comb begin
        overflow_d = overflow_q;
        skew_err_d = skew_err_q;
        if (clear_i) begin
            overflow_d = 1'b0;
            skew_err_d = 1'b0;
        end
        if (ovf_event) begin
            overflow_d = 1'b1;
        end
        if (skew_event) begin
            skew_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q <= 1'b0;
            skew_err_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
            skew_err_q <= skew_err_d;
        end
    end

    assign overflow_o = overflow_q;
    assign skew_err_o = skew_err_q;

endmodule

// File: tb/tb_sa_psum_deskew.sv
// Directed bench for sa_psum_deskew: a queue-based row model checked every
// cycle, plus literal expectations at the key points of each scenario.
module tb_sa_psum_deskew;

    localparam int PE = 2;
    localparam int W  = 32;
    localparam int D  = 4;
    localparam int LW = $clog2(D+1);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [PE*W-1:0]   psum_row_i = '0;
    logic [PE-1:0]     psum_en_row_i = '0;
    logic              clear_i = 1'b0;
    logic [PE*W-1:0]   out_row_o;
    logic              out_valid_o;
    logic              out_ready_i = 1'b0;
    logic [LW-1:0]     level_o;
    logic              overflow_o;
    logic              skew_err_o;

    int n_pass = 0;
    int n_total = 0;

    sa_psum_deskew #(.PE_SIZE(PE), .PSUM_WIDTH(W), .FIFO_DEPTH(D)) dut (
        .clk           (clk),
        .rst           (rst),
        .psum_row_i    (psum_row_i),
        .psum_en_row_i (psum_en_row_i),
        .clear_i       (clear_i),
        .out_row_o     (out_row_o),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .level_o       (level_o),
        .overflow_o    (overflow_o),
        .skew_err_o    (skew_err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [PE*W-1:0] act, input logic [PE*W-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // History of driven inputs, newest first; column j lines up with the last
    // column when taken from PE-1-j cycles ago.
    logic [PE-1:0]   en_h  [PE];
    logic [PE*W-1:0] row_h [PE];
    logic [PE*W-1:0] mq [$];
    logic            m_ovf = 1'b0;
    logic            m_skew = 1'b0;

    initial begin
        for (int k = 0; k < PE; k++) begin
            en_h[k] = '0;
            row_h[k] = '0;
        end
    end

    always @(posedge clk) begin
        logic [PE*W-1:0] arow;
        logic [PE-1:0]   aen;
        bit popped, ovf_ev, skew_ev;
        if (rst) begin
            for (int k = 0; k < PE; k++) begin
                en_h[k] = '0;
                row_h[k] = '0;
            end
            mq.delete();
            m_ovf = 1'b0;
            m_skew = 1'b0;
        end else begin
            for (int k = PE-1; k > 0; k--) begin
                en_h[k] = en_h[k-1];
                row_h[k] = row_h[k-1];
            end
            en_h[0] = psum_en_row_i;
            row_h[0] = psum_row_i;
            arow = '0;
            aen = '0;
            for (int j = 0; j < PE; j++) begin
                aen[PE-1-j] = en_h[PE-1-j][PE-1-j];
                arow[W*(PE-j)-1 -: W] = row_h[PE-1-j][W*(PE-j)-1 -: W];
            end
            popped = (mq.size() > 0) && out_ready_i;
            ovf_ev = 0;
            skew_ev = (aen != '0) && (aen != '1);
            if (popped) void'(mq.pop_front());
            if (aen == '1) begin
                if (mq.size() < D) mq.push_back(arow);
                else ovf_ev = 1;
            end
            if (clear_i) begin
                m_ovf = 1'b0;
                m_skew = 1'b0;
            end
            if (ovf_ev) m_ovf = 1'b1;
            if (skew_ev) m_skew = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_valid", PE*W'(out_valid_o), '0);
            chk("rst_level", PE*W'(level_o), '0);
            chk("rst_ovf", PE*W'(overflow_o), '0);
            chk("rst_skew", PE*W'(skew_err_o), '0);
        end else begin
            chk("m_valid", PE*W'(out_valid_o), PE*W'(mq.size() != 0));
            chk("m_level", PE*W'(level_o), PE*W'(mq.size()));
            chk("m_ovf", PE*W'(overflow_o), PE*W'(m_ovf));
            chk("m_skew", PE*W'(skew_err_o), PE*W'(m_skew));
            if (mq.size() != 0) chk("m_row", out_row_o, mq[0]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [PE-1:0] en, input logic [W-1:0] c0, input logic [W-1:0] c1);
        psum_en_row_i = en;
        psum_row_i = {c0, c1};
        step();
        psum_en_row_i = '0;
        psum_row_i = '0;
    endtask

    function automatic logic [PE*W-1:0] row_of(input int r);
        logic [W-1:0] a, b;
        a = W'(32'h100 + r);
        b = W'(32'h200 + r);
        return {a, b};
    endfunction

    // Rows first..first+n-1 back to back; ready is raised only in the cycle
    // whose aligning row index equals ready_row.
    task automatic skewed_rows(input int first, input int n, input int ready_row, input int clear_row);
        for (int i = 0; i <= n; i++) begin
            out_ready_i = (i > 0) && (first + i - 1 == ready_row);
            clear_i = (i > 0) && (first + i - 1 == clear_row);
            drive({i < n, i > 0}, W'(32'h100 + first + i), W'(32'h200 + first + i - 1));
        end
        out_ready_i = 1'b0;
        clear_i = 1'b0;
    endtask

    initial begin
        step();
        step();
        rst = 1'b0;

        // reset mid-row
        drive(2'b10, 32'h11, 32'h0);
        rst = 1'b1;
        drive(2'b01, 32'h0, 32'h22);
        step();
        rst = 1'b0;
        step();
        step();
        chk("midrst_valid", PE*W'(out_valid_o), '0);
        chk("midrst_level", PE*W'(level_o), '0);
        chk("midrst_flags", PE*W'({overflow_o, skew_err_o}), '0);

        // single row
        drive(2'b10, 32'h11, 32'h0);
        drive(2'b01, 32'h0, 32'h22);
        chk("single_valid", PE*W'(out_valid_o), PE*W'(1));
        chk("single_row", out_row_o, {32'h11, 32'h22});
        chk("single_level", PE*W'(level_o), PE*W'(1));
        out_ready_i = 1'b1;
        step();
        out_ready_i = 1'b0;
        chk("single_drained", PE*W'(out_valid_o), '0);

        // fill and overflow
        skewed_rows(1, 5, -1, -1);
        chk("fill_level", PE*W'(level_o), PE*W'(4));
        chk("fill_ovf", PE*W'(overflow_o), PE*W'(1));
        out_ready_i = 1'b1;
        for (int r = 1; r <= 4; r++) begin
            chk("drain_row", out_row_o, row_of(r));
            step();
        end
        out_ready_i = 1'b0;
        chk("drain_empty", PE*W'(out_valid_o), '0);

        // skew error
        drive(2'b10, 32'h33, 32'h0);
        drive(2'b00, 32'h0, 32'h44);
        chk("skew_flag", PE*W'(skew_err_o), PE*W'(1));
        chk("skew_level", PE*W'(level_o), '0);

        // clear both flags
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        chk("clear_flags", PE*W'({overflow_o, skew_err_o}), '0);

        // full with simultaneous pop: row 10 aligns while rows 6..9 fill the FIFO
        skewed_rows(6, 5, 10, -1);
        chk("fullpop_level", PE*W'(level_o), PE*W'(4));
        chk("fullpop_ovf", PE*W'(overflow_o), '0);
        chk("fullpop_head", out_row_o, row_of(7));

        // clear coincident with a new overflow
        skewed_rows(11, 1, -1, 11);
        chk("clear_vs_ovf", PE*W'(overflow_o), PE*W'(1));
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        chk("clear_after", PE*W'(overflow_o), '0);

        out_ready_i = 1'b1;
        for (int r = 7; r <= 10; r++) begin
            chk("final_row", out_row_o, row_of(r));
            step();
        end
        out_ready_i = 1'b0;
        chk("final_empty", PE*W'(out_valid_o), '0);
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
